led_fade_pwm: RTL
=================

// Module: led_fade_pwm
// PURPOSE
//  Port-mapped LED driver that sits downstream of the KCPSM6 output bus and
//  replaces the plain per-bit LED latch. Each LED has an 8-bit brightness level
//  rendered by PWM. A lit LED holds the programmed ceiling level. A released LED
//  fades out at a programmable rate, giving a hardware trailing glow for the
//  scanner (night-rider) pattern without extra firmware delay loops.
// PARAMETERS
//  NUM_LEDS   4         number of LED channels (1..8)
//  BASE_PORT  8'h00     first port_id of the 3-register window
//  DECAY_DIV  50000     clk cycles per decay tick (>=2)
// PORTS
//  clk           in   1         system clock, all logic on rising edge
//  reset         in   1         synchronous, active-high
//  write_strobe  in   1         KCPSM6 write qualifier
//  port_id       in   8         KCPSM6 port address
//  out_port      in   8         KCPSM6 write data
//  rd_data       out  8         readback data, OR-able into in_port
//  led_out       out  NUM_LEDS  PWM LED drive, registered
// BEHAVIOUR
//  Reset values:
//   - mask=0, level[i]=0, ceil=8'hFF, step=8'h10
//   - pwm_cnt=0, presc=0, led_out=0, rd_data=0
//  Register map (written when write_strobe=1 and port_id matches):
//   - BASE+0  mask[NUM_LEDS-1:0] <= out_port[NUM_LEDS-1:0]; upper bits ignored
//   - BASE+1  ceil <= out_port
//   - BASE+2  step <= out_port
//   - Any other port_id, or write_strobe=0: no state change
//  PWM:
//   - pwm_cnt runs 0..254, then wraps to 0 (period 255 clk)
//   - led_out[i] <= (pwm_cnt < level[i]), registered, 1 clk after the compare
//   - level 0 is always off; level 255 is always on
//  Decay prescaler:
//   - presc counts 0..DECAY_DIV-1
//   - tick=1 for the single cycle when presc==DECAY_DIV-1, then presc wraps to 0
//  Level update, per LED each cycle, in priority order:
//   1. mask[i]=1: level[i] <= ceil. This includes a ceil written in the previous
//      cycle, so a lit LED follows a new ceiling 1 clk after the write.
//   2. mask[i]=0 and tick: level[i] <= (level[i] > step) ? level[i]-step : 0.
//      Saturating subtraction, never wraps below 0.
//   3. Otherwise level[i] holds.
//  Timing:
//   - mask/ceil/step become visible 1 clk after the write
//   - level uses the updated mask the clk after that
//  Simultaneous events:
//   - Write to mask on a tick cycle: the tick decays with the OLD mask and step.
//     The new mask takes effect the next cycle.
//   - A newly cleared LED starts fading from its current level at the next tick.
//     It does not restart from ceil.
//   - step=0: released LEDs freeze at their current level.
//   - ceil=0: lit LEDs are dark.
//  Reset mid-fade: all levels return to 0 and led_out to 0 on the next edge.
//   The prescaler restarts at 0.
// CONFIGURATION
//  LED_FADE_READBACK_EN defined:
//   - rd_data is registered, 1 clk after port_id
//   - BASE+0 -> {0, mask}, BASE+1 -> ceil, BASE+2 -> step, BASE+3 -> level[0]
//   - any other port_id -> 8'h00
//  LED_FADE_READBACK_EN undefined:
//   - rd_data tied to 8'h00; no readback mux is built
// TESTING (bench overrides DECAY_DIV=4)
//  1. Reset held 2 clk -> led_out=0 throughout.
//     With readback: rd@BASE+1 = FF, rd@BASE+2 = 10.
//  2. Write 8'h01 to BASE+0 -> level[0]=FF two clk later.
//     led_out[0] then stays 1 for all 255 cycles of a PWM period;
//     led_out[3:1] stay 0.
//  3. Write ceil=8'h80, then mask=8'h03 -> led_out[0] and led_out[1] are each
//     high for exactly 128 of every 255 clk.
//  4. Mask=01, then mask=00 with step=10 -> level[0] decays FF,EF,...,0F,00 on
//     successive ticks (4 clk apart), then stays 00 with no wrap.
//  5. Mask write 8'h00 landing on a tick cycle while mask=01 -> level[0] stays FF
//     on that tick. The first decrement (to EF) occurs on the following tick.
//  6. Write to port_id BASE+5, and a write to BASE+0 with write_strobe=0
//     -> no change to mask, ceil, step or levels.
//     Separately, reset asserted mid-fade -> levels 0 and led_out=0 next clk.

Source files
------------

// File: rtl/led_fade_pwm.sv
// KCPSM6 port-mapped LED driver: per-LED 8-bit PWM brightness with a hardware fade-out on release.
// Optional register readback is built only when LED_FADE_READBACK_EN is defined.
module led_fade_pwm #(
    parameter int         NUM_LEDS  = 4,
    parameter logic [7:0] BASE_PORT = 8'h00,
    parameter int         DECAY_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_strobe,
    input  logic [7:0]          port_id,
    input  logic [7:0]          out_port,
    output logic [7:0]          rd_data,
    output logic [NUM_LEDS-1:0] led_out
);

    localparam int                 PRESC_W    = $clog2(DECAY_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DECAY_DIV - 1);
    localparam logic [7:0]         PWM_LAST   = 8'd254;
    localparam logic [7:0]         PORT_MASK  = BASE_PORT;
    localparam logic [7:0]         PORT_CEIL  = BASE_PORT + 8'd1;
    localparam logic [7:0]         PORT_STEP  = BASE_PORT + 8'd2;

    logic [NUM_LEDS-1:0]      mask_r;
    logic [7:0]               ceil_r;
    logic [7:0]               step_r;
    logic [NUM_LEDS-1:0][7:0] level_r;
    logic [7:0]               pwm_cnt_r;
    logic [PRESC_W-1:0]       presc_r;
    logic [NUM_LEDS-1:0]      led_out_r;
    logic                     tick_s;
    logic                     wr_mask_s;
    logic                     wr_ceil_s;
    logic                     wr_step_s;

    // Level decrement that clamps at zero instead of wrapping.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        if (a > b) begin
            return a - b;
        end else begin
            return 8'h00;
        end
    endfunction

    // Decode KCPSM6 writes into per-register enables.
    always_comb begin
        wr_mask_s = 1'b0;
        wr_ceil_s = 1'b0;
        wr_step_s = 1'b0;
        if (write_strobe) begin
            case (port_id)
                PORT_MASK: wr_mask_s = 1'b1;
                PORT_CEIL: wr_ceil_s = 1'b1;
                PORT_STEP: wr_step_s = 1'b1;
                default: begin
                    wr_mask_s = 1'b0;
                    wr_ceil_s = 1'b0;
                    wr_step_s = 1'b0;
                end
            endcase
        end else begin
            wr_mask_s = 1'b0;
            wr_ceil_s = 1'b0;
            wr_step_s = 1'b0;
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    // Control registers written from the processor port.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= '0;
            ceil_r <= 8'hFF;
            step_r <= 8'h10;
        end else begin
            if (wr_mask_s) mask_r <= out_port[NUM_LEDS-1:0];
            if (wr_ceil_s) ceil_r <= out_port;
            if (wr_step_s) step_r <= out_port;
        end
    end

    // Decay prescaler; tick_s marks its last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // PWM counter with a 255-cycle period so level 255 is fully on.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_r <= 8'h00;
        end else if (pwm_cnt_r == PWM_LAST) begin
            pwm_cnt_r <= 8'h00;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end
    end

    // Brightness per LED: lit LEDs track ceil, released LEDs fade on each tick.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (reset) begin
                level_r[i] <= 8'h00;
            end else if (mask_r[i]) begin
                level_r[i] <= ceil_r;
            end else if (tick_s) begin
                level_r[i] <= sat_sub(level_r[i], step_r);
            end else begin
                level_r[i] <= level_r[i];
            end
        end
    end

    // Registered PWM compare drives the LED pins.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (reset) begin
                led_out_r[i] <= 1'b0;
            end else begin
                led_out_r[i] <= (pwm_cnt_r < level_r[i]);
            end
        end
    end

    assign led_out = led_out_r;

`ifdef LED_FADE_READBACK_EN
    localparam logic [7:0] PORT_LEVEL = BASE_PORT + 8'd3;

    logic [7:0] rd_sel_s;
    logic [7:0] rd_mask_s;
    logic [7:0] rd_data_r;

    // Readback mux over the register window.
    always_comb begin
        rd_mask_s                 = 8'h00;
        rd_mask_s[NUM_LEDS-1:0]   = mask_r;
        rd_sel_s                  = 8'h00;
        case (port_id)
            PORT_MASK:  rd_sel_s = rd_mask_s;
            PORT_CEIL:  rd_sel_s = ceil_r;
            PORT_STEP:  rd_sel_s = step_r;
            PORT_LEVEL: rd_sel_s = level_r[0];
            default:    rd_sel_s = 8'h00;
        endcase
    end

    // Registered readback data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= 8'h00;
        end else begin
            rd_data_r <= rd_sel_s;
        end
    end

    assign rd_data = rd_data_r;
`else
    assign rd_data = 8'h00;
`endif

endmodule
